// File: rtl/rom4001_bus.sv
// rom4001_bus: one MCS-4 program ROM (256x8) on the shared 4-bit bus, plus its 4-bit I/O port.
// Latency: instruction nibbles are driven from the edge entering M1/M2; RDR data from the edge entering X2.
// Backpressure: none; the bus is strictly phase-timed and a sync pulse resynchronises from any phase.
//
// Ports:
//   clk, rst_n            one clock per bus phase; asynchronous active-low reset
//   sync_i                CPU sync (high during X3), next phase is A1
//   cm_rom_i              ROM command line (A3 page select, M2 I/O op, X2 SRC)
//   d_i                   resolved bus value (includes this chip's own drive)
//   d_o, d_oe             registered bus drive nibble and enable
//   cyc_o, cyc_vld_o      current phase (A1=0 .. X3=7) and tracker-locked flag
//   io_in, io_out         I/O port pins (read by RDR) and port latch (written by WRR)
//   prog_we/addr/data     array load path, usable in any phase
module rom4001_bus #(
  parameter logic [3:0] CHIP_ID   = 4'd0,
  parameter             INIT_FILE = ""
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sync_i,
  input  logic       cm_rom_i,
  input  logic [3:0] d_i,
  output logic [3:0] d_o,
  output logic       d_oe,
  output logic [2:0] cyc_o,
  output logic       cyc_vld_o,
  input  logic [3:0] io_in,
  output logic [3:0] io_out,
  input  logic       prog_we,
  input  logic [7:0] prog_addr,
  input  logic [7:0] prog_data
);

  // Bus phases of the 8-clock instruction cycle.
  localparam logic [2:0] PH_A1 = 3'd0;
  localparam logic [2:0] PH_A2 = 3'd1;
  localparam logic [2:0] PH_A3 = 3'd2;
  localparam logic [2:0] PH_M1 = 3'd3;
  localparam logic [2:0] PH_M2 = 3'd4;
  localparam logic [2:0] PH_X1 = 3'd5;
  localparam logic [2:0] PH_X2 = 3'd6;
  localparam logic [2:0] PH_X3 = 3'd7;

  // Instruction codes this chip reacts to.
  localparam logic [3:0] OPR_FIM_SRC = 4'h2;  // FIM/SRC group; SRC has opa[0]=1
  localparam logic [3:0] OPR_IORAM   = 4'hE;  // I/O and RAM group
  localparam logic [3:0] OPA_WRR     = 4'h2;
  localparam logic [3:0] OPA_RDR     = 4'hA;

  logic [2:0] r_cyc;
  logic       r_vld;
  logic [7:0] r_addr;
  logic       r_sel;
  logic [3:0] r_opr;
  logic [3:0] r_opa;
  logic       r_io_cmd;
  logic       r_io_sel;
  logic [3:0] r_io_out;
  logic [3:0] r_d_o;
  logic       r_d_oe;
  logic [7:0] r_mem [0:255];

  logic       w_adv;
  logic       w_page_hit;
  logic       w_chip_hit;
  logic [7:0] w_rom_byte;
  logic       w_src;
  logic       w_wrr;
  logic       w_rdr;

  // Phase tracker only advances once locked; a sync pulse always wins so the
  // chip follows the CPU even if it gets out of step.
  assign w_adv      = r_vld && !sync_i;
  assign w_chip_hit = (d_i == CHIP_ID);
  assign w_page_hit = cm_rom_i && w_chip_hit;
  assign w_rom_byte = r_mem[r_addr];
  assign w_src      = (r_opr == OPR_FIM_SRC) && r_opa[0];
  assign w_wrr      = (r_opr == OPR_IORAM) && (r_opa == OPA_WRR) && r_io_cmd;
  assign w_rdr      = (r_opr == OPR_IORAM) && (r_opa == OPA_RDR) && r_io_cmd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cyc <= PH_A1;
      r_vld <= 1'b0;
    end else if (sync_i) begin
      r_cyc <= PH_A1;
      r_vld <= 1'b1;
    end else if (r_vld) begin
      r_cyc <= r_cyc + 3'd1;  // X3 wraps to A1 through the 3-bit overflow
    end
  end

  // Address latch, instruction snoop and I/O port state. Every chip snoops the
  // opcode, selected or not, so SRC/WRR/RDR work regardless of the fetch page.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr   <= 8'h00;
      r_sel    <= 1'b0;
      r_opr    <= 4'h0;
      r_opa    <= 4'h0;
      r_io_cmd <= 1'b0;
      r_io_sel <= 1'b0;
      r_io_out <= 4'h0;
    end else if (r_vld) begin
      case (r_cyc)
        PH_A1: r_addr[3:0] <= d_i;
        PH_A2: r_addr[7:4] <= d_i;
        PH_A3: r_sel       <= w_page_hit;
        PH_M1: r_opr       <= d_i;
        PH_M2: begin
          r_opa    <= d_i;
          r_io_cmd <= cm_rom_i;
        end
        PH_X2: begin
          // SRC carries the chip number in X2; selection persists until the next SRC.
          if (w_src && cm_rom_i) begin
            r_io_sel <= w_chip_hit;
          end
          if (w_wrr && r_io_sel) begin
            r_io_out <= d_i;
          end
        end
        default: ;
      endcase
    end
  end

  // Bus drive is decided one phase early so it is registered on the edge
  // entering M1/M2/X2 and dropped on the edge leaving it. A resync edge never
  // drives, which abandons a partial fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d_o  <= 4'h0;
      r_d_oe <= 1'b0;
    end else begin
      r_d_o  <= 4'h0;
      r_d_oe <= 1'b0;
      if (w_adv) begin
        case (r_cyc)
          PH_A3: begin
            // Page select is decided on this same edge, so use the live compare.
            if (w_page_hit) begin
              r_d_o  <= w_rom_byte[7:4];
              r_d_oe <= 1'b1;
            end
          end
          PH_M1: begin
            if (r_sel) begin
              r_d_o  <= w_rom_byte[3:0];
              r_d_oe <= 1'b1;
            end
          end
          PH_X1: begin
            if (w_rdr && r_io_sel) begin
              r_d_o  <= io_in;
              r_d_oe <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Program array: written from the load path in any phase; not reset.
  always_ff @(posedge clk) begin
    if (prog_we) begin
      r_mem[prog_addr] <= prog_data;
    end
  end

  assign d_o       = r_d_o;
  assign d_oe      = r_d_oe;
  assign cyc_o     = r_cyc;
  assign cyc_vld_o = r_vld;
  assign io_out    = r_io_out;

endmodule
